// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: one write port and NUM_READ packed read ports.
// The master side (writeback/decode) drives addresses and write data.
// The slave side (register file) returns registered read data.
interface regfile_mp_if #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_READ = 2
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                         we;
    logic [ADDR_W-1:0]            wr_addr;
    logic [WIDTH-1:0]             wr_data;
    logic [NUM_READ*ADDR_W-1:0]   rd_addr;
    logic [NUM_READ*WIDTH-1:0]    rd_data;

    modport master (
        output we,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  we,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with one synchronous write port and
// NUM_READ registered read ports. Entry 0 is hardwired to zero.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a read of the address being written on the same edge returns
//                the incoming write data (write-first).
//   undefined -> the same read returns the previously stored value
//                (read-first); the new value appears one edge later.
// Address 0 and reset behave identically in both builds.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_READ = 2
) (
    input  logic         clock,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    // Address width is always derived from the depth.
    localparam int ADDR_W = $clog2(DEPTH);

    // Reject configurations the selection path was not built for.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("regfile_mp: DEPTH must be a power of two and at least 2");
    end
    if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_ports
        $error("regfile_mp: NUM_READ must be between 1 and 4");
    end

    // Storage; entry 0 is kept at zero and never written.
    logic [WIDTH-1:0]           mem_r [DEPTH];
    // Per-port unpacked read addresses.
    logic [ADDR_W-1:0]          rd_addr_s [NUM_READ];
    // Next-cycle read data for all ports, packed like the output bus.
    logic [NUM_READ*WIDTH-1:0]  rd_next_s;
    // Registered read data driving the bus.
    logic [NUM_READ*WIDTH-1:0]  rd_data_r;
    // A write that actually lands in storage (nonzero address).
    logic                       wr_en_s;

    assign wr_en_s = bus.we && (bus.wr_addr != {ADDR_W{1'b0}});

    // Split the packed read-address bus into one address per port.
    always_comb begin
        rd_addr_s = '{default: '0};
        for (int p = 0; p < NUM_READ; p++) begin
            rd_addr_s[p] = bus.rd_addr[p*ADDR_W +: ADDR_W];
        end
    end

    // Storage update: reset clears every entry; writes to entry 0 are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            mem_r[0] <= {WIDTH{1'b0}};
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_en_s && (bus.wr_addr == ADDR_W'(i))) begin
                    mem_r[i] <= bus.wr_data;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

    // Read selection per port: zero register, optional write bypass, storage.
    always_comb begin
        rd_next_s = {(NUM_READ*WIDTH){1'b0}};
        for (int p = 0; p < NUM_READ; p++) begin
            if (rd_addr_s[p] == {ADDR_W{1'b0}}) begin
                // Zero register wins over any write in flight.
                rd_next_s[p*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            end
`ifdef REGFILE_BYPASS_EN
            else if (wr_en_s && (bus.wr_addr == rd_addr_s[p])) begin
                // Write-first: forward the data being written this edge.
                rd_next_s[p*WIDTH +: WIDTH] = bus.wr_data;
            end
`endif
            else begin
                rd_next_s[p*WIDTH +: WIDTH] = mem_r[rd_addr_s[p]];
            end
        end
    end

    // Read output register: one-cycle read latency, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_r <= {(NUM_READ*WIDTH){1'b0}};
        end else begin
            rd_data_r <= rd_next_s;
        end
    end

    assign bus.rd_data = rd_data_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp with four read ports. Each driven cycle
// pushes the expected read data for that edge; a monitor pops one entry after
// every rising edge and compares it with the registered outputs.
module tb_regfile_mp;
    localparam int WIDTH    = 32;
    localparam int DEPTH    = 32;
    localparam int NUM_READ = 4;
    localparam int ADDR_W   = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    regfile_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_READ(NUM_READ)) bus ();

    regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_READ(NUM_READ)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit                          chk;
        logic [NUM_READ*WIDTH-1:0]   exp;
        string                       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [NUM_READ*ADDR_W-1:0] ra4(input int a0, input int a1,
                                                        input int a2, input int a3);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    function automatic logic [NUM_READ*WIDTH-1:0] d4(input logic [31:0] d0, input logic [31:0] d1,
                                                      input logic [31:0] d2, input logic [31:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    // One stimulus cycle: drive inputs away from the edge, queue the expectation.
    task automatic cycle(input logic rst, input logic we, input int wa, input logic [31:0] wd,
                         input logic [NUM_READ*ADDR_W-1:0] ra, input bit chk,
                         input logic [NUM_READ*WIDTH-1:0] exp, input string name);
        exp_t e;
        @(negedge clock);
        reset       = rst;
        bus.we      = we;
        bus.wr_addr = 5'(wa);
        bus.wr_data = wd;
        bus.rd_addr = ra;
        e.chk  = chk;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Monitor: after each rising edge, compare outputs with the queued expectation.
    always @(posedge clock) begin
        #2;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk) begin
                n_checks++;
                if (bus.rd_data !== mon_e.exp) begin
                    n_fail++;
                    $display("FAIL %s: rd_data=%h expected %h", mon_e.name, bus.rd_data, mon_e.exp);
                end
            end
        end
    end

    logic [31:0] b7, b31, b9, b10;

    initial begin
        reset       = 1'b1;
        bus.we      = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;

        b7  = BYP ? 32'd7 : 32'd3;
        b31 = BYP ? 32'h1234_5678 : 32'h0;
        b9  = BYP ? 32'h55 : 32'h0;
        b10 = BYP ? 32'h66 : 32'h0;

        // Reset held two cycles with a write presented; outputs must be zero.
        cycle(1'b1, 1'b1, 5, 32'hDEAD_BEEF, ra4(5,5,5,5), 1'b1, '0, "reset_hold_1");
        cycle(1'b1, 1'b1, 5, 32'hDEAD_BEEF, ra4(5,5,5,5), 1'b1, '0, "reset_hold_2");
        cycle(1'b0, 1'b0, 0, 32'h0, ra4(5,5,5,5), 1'b1, '0, "reset_write_dropped");

        // Basic write/read and one-cycle write latency.
        cycle(1'b0, 1'b1, 23, 32'd23, ra4(0,0,0,0), 1'b1, '0, "idle_zero");
        cycle(1'b0, 1'b1, 17, 32'd17, ra4(23,23,23,23), 1'b1, d4(23,23,23,23), "write_latency");
        cycle(1'b0, 1'b0, 0, 32'h0, ra4(17,23,0,5), 1'b1, d4(17,23,0,0), "basic_rw");

        // Zero register ignores writes, even on the same edge.
        cycle(1'b0, 1'b1, 0, 32'hFFFF_FFFF, ra4(0,0,0,0), 1'b1, '0, "zero_same_edge");
        cycle(1'b0, 1'b0, 0, 32'h0, ra4(0,0,0,0), 1'b1, '0, "zero_after_write");

        // Bypass collision on address 7 (prior value 3).
        cycle(1'b0, 1'b1, 7, 32'd3, ra4(17,17,17,17), 1'b1, d4(17,17,17,17), "multi_17");
        cycle(1'b0, 1'b1, 7, 32'd7, ra4(7,17,23,0), 1'b1, d4(b7,17,23,0), "bypass_collision");
        cycle(1'b0, 1'b1, 31, 32'h1234_5678, ra4(7,7,0,31), 1'b1, d4(7,7,0,b31), "post_collision");

        // All four ports on the same address.
        cycle(1'b0, 1'b0, 0, 32'h0, ra4(31,31,31,31), 1'b1,
              d4(32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678), "multiport_31");

        // Write burst with reset landing on the fourth write.
        cycle(1'b0, 1'b1, 1, 32'hA1, ra4(31,0,0,0), 1'b1, d4(32'h1234_5678,0,0,0), "burst_w1");
        cycle(1'b0, 1'b1, 2, 32'hA2, ra4(1,0,0,0), 1'b1, d4(32'hA1,0,0,0), "burst_w2");
        cycle(1'b0, 1'b1, 3, 32'hA3, ra4(2,1,0,0), 1'b1, d4(32'hA2,32'hA1,0,0), "burst_w3");
        cycle(1'b1, 1'b1, 4, 32'hA4, ra4(1,2,3,4), 1'b1, '0, "reset_mid");
        cycle(1'b0, 1'b0, 0, 32'h0, ra4(1,2,3,4), 1'b1, '0, "after_reset_1_4");
        cycle(1'b0, 1'b0, 0, 32'h0, ra4(31,17,23,7), 1'b1, '0, "after_reset_other");

        // Bypass seen by several ports at once, and no false bypass on other addresses.
        cycle(1'b0, 1'b1, 9, 32'h55, ra4(0,9,9,9), 1'b1, d4(0,b9,b9,b9), "bypass_multi");
        cycle(1'b0, 1'b0, 0, 32'h0, ra4(9,9,9,9), 1'b1, d4(32'h55,32'h55,32'h55,32'h55), "read_9");
        cycle(1'b0, 1'b1, 10, 32'h66, ra4(9,10,9,0), 1'b1, d4(32'h55,b10,32'h55,0), "bypass_other_addr");
        cycle(1'b0, 1'b0, 0, 32'h0, ra4(10,0,0,10), 1'b1, d4(32'h66,0,0,32'h66), "read_10");

        // Let the monitor drain the queue, with a bounded wait.
        for (int i = 0; i < 8 && sb_q.size() > 0; i++) begin
            @(posedge clock);
            #4;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with synchronous write and registered read ports, built on the 32-to-1 selection path of the processor datapath. Replaces per-port wide muxes feeding the decode stage with one block that owns storage, read selection, the hardwired zero register and optional write-to-read bypass. It sits between the writeback stage (write port) and the decode stage (read ports).

## Interface
- `WIDTH`, 32, data bits per register.
- `DEPTH`, 32, number of registers; power of two, minimum 2.
- `ADDR_W`, `$clog2(DEPTH)`, address width; derived, never overridden.
- `NUM_READ`, 2, number of independent read ports; 1 to 4.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; clears storage and read outputs.
- `we`  in  1  write enable.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  WIDTH  write data.
- `rd_addr`  in  NUM_READ*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- `rd_data`  out  NUM_READ*WIDTH  registered read data; port p on bits [p*WIDTH +: WIDTH].

## Operation
- Storage: DEPTH entries of WIDTH bits. Entry 0 always reads 0; writes to address 0 are discarded.
- Write: at a rising edge with `reset`=0 and `we`=1 and `wr_addr`≠0, entry `wr_addr` ← `wr_data`.
- Read: at every rising edge with `reset`=0, each port p loads its `rd_data` slice with the selected entry for `rd_addr[p]`. Ports are fully independent; several ports may read the same address in the same cycle.
- Read of address 0 returns 0 regardless of any write in flight.
- Same-cycle write and read of the same nonzero address: result governed by `REGFILE_BYPASS_EN` (see Configuration).
- Reset: at a rising edge with `reset`=1, all entries and all `rd_data` slices become 0; `we` ignored that cycle. Reset mid-operation (e.g. during a burst of writes) discards the write presented in the reset cycle; writes before it are also lost since storage is cleared.
- No X propagation: storage and outputs are defined from the first reset onward.

## Timing
- Write latency: data written at edge N is visible to a read sampled at edge N+1 (output valid after N+1), independent of configuration.
- Read latency: 1 cycle. `rd_addr` sampled at edge N produces `rd_data` valid after edge N, held until edge N+1.
- Reset value of every output: `rd_data` = 0 on all ports after the first reset edge.
- No handshake; a read and a write may be issued every cycle with no stall.
- Combinational path from inputs to `rd_data`: none (outputs are flops).

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined: a read at edge N of nonzero address A while `we`=1 and `wr_addr`=A returns `wr_data` (write-first). Effective write-to-read latency 0 for the same edge.
- Undefined: the same read returns the value stored in A before edge N (read-first); the new value appears from the read at edge N+1.
- Address-0 behaviour and reset behaviour are identical in both builds.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with `we`=1, `wr_addr`=5, `wr_data`=0xDEADBEEF -> all `rd_data` = 0; after release, read address 5 -> 0.
- Basic write/read: write 17 to address 17, then next cycle read port 0 addr 17, port 1 addr 23 (written 23 earlier) -> port 0 = 17, port 1 = 23 one cycle after the read edge.
- Zero register: write 0xFFFFFFFF to address 0, read address 0 on all ports -> 0.
- Bypass collision: write 0x0000_0007 to address 7 (prior value 0x0000_0003) while port 0 reads 7 on the same edge -> 7 with `REGFILE_BYPASS_EN`, 3 without; following read -> 7 in both builds.
- Multi-port same address: NUM_READ=4, all ports read address 31 holding 0x1234_5678 -> all four slices = 0x1234_5678.
- Reset mid-stream: writes to addresses 1..4 on consecutive cycles, `reset` asserted on the cycle of write 4 -> reads of 1..4 all return 0.
